// File: rtl/len_table_pkg.sv
// Opcode set of the shared ALU and the fused-uop case table walked by fuse_seq_ctrl.
// Case 1 carries a forwarding bubble after its first uop.
package uop_pkg;
    typedef enum logic [3:0] {
        OP_NOP  = 4'd0,
        OP_ADD  = 4'd1,
        OP_SUB  = 4'd2,
        OP_IMUL = 4'd3,
        OP_INC  = 4'd4,
        OP_SHL  = 4'd5
    } op_t;
endpackage

package len_table_pkg;
    import uop_pkg::*;

    localparam int N_CASE  = 3;
    localparam int MAX_LEN = 2;
    localparam int CW      = (N_CASE > 1) ? $clog2(N_CASE) : 1;
    localparam int SW      = $clog2(MAX_LEN + 1);

    typedef logic [SW-1:0] len_t;

    localparam len_t LEN_LUT [N_CASE] = '{len_t'(2), len_t'(2), len_t'(2)};

    localparam op_t OPS_LUT [N_CASE][MAX_LEN] = '{
        '{OP_IMUL, OP_ADD},
        '{OP_ADD,  OP_SUB},
        '{OP_INC,  OP_SHL}
    };

    // Bit i refers to step i of the case.
    localparam logic [MAX_LEN-1:0] USE_IMM_LUT [N_CASE] = '{2'b00, 2'b01, 2'b10};
    localparam logic [MAX_LEN-1:0] FF_MASK_LUT [N_CASE] = '{2'b00, 2'b01, 2'b00};

    localparam logic [31:0] IMM_LUT [N_CASE][MAX_LEN] = '{
        '{32'd0, 32'd0},
        '{32'd5, 32'd0},
        '{32'd0, 32'd2}
    };
endpackage

// File: rtl/fuse_seq_ctrl_if.sv
// Request, ALU issue/response and result channels of the fused-op sequencer.
// master is the sequencer side, slave is the decode/ALU/consumer side.
interface fuse_seq_if #(
    parameter int XLEN = 32
);
    logic                           in_valid;
    logic                           in_ready;
    logic [len_table_pkg::CW-1:0]   in_case;
    logic [XLEN-1:0]                in_a;
    logic [XLEN-1:0]                in_b;

    logic                           alu_req_valid;
    logic                           alu_req_ready;
    uop_pkg::op_t                   alu_op;
    logic [XLEN-1:0]                alu_a;
    logic [XLEN-1:0]                alu_b;
    logic                           alu_rsp_valid;
    logic [XLEN-1:0]                alu_rsp_data;

    logic                           out_valid;
    logic                           out_ready;
    logic [XLEN-1:0]                out_data;
    logic                           out_err;

    modport master (
        input  in_valid, in_case, in_a, in_b,
        output in_ready,
        output alu_req_valid, alu_op, alu_a, alu_b,
        input  alu_req_ready, alu_rsp_valid, alu_rsp_data,
        output out_valid, out_data, out_err,
        input  out_ready
    );

    modport slave (
        output in_valid, in_case, in_a, in_b,
        input  in_ready,
        input  alu_req_valid, alu_op, alu_a, alu_b,
        output alu_req_ready, alu_rsp_valid, alu_rsp_data,
        input  out_valid, out_data, out_err,
        output out_ready
    );
endinterface

// File: rtl/fuse_seq_ctrl.sv
// Fused-uop sequencer: walks one case of len_table_pkg through a shared ALU, chaining results.
// Optional macro FUSE_SEQ_PERF_EN adds saturating request/stall/error counters.
module fuse_seq_ctrl #(
    parameter int N_CASE  = len_table_pkg::N_CASE,
    parameter int MAX_LEN = len_table_pkg::MAX_LEN,
    parameter int XLEN    = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    fuse_seq_if.master  bus
`ifdef FUSE_SEQ_PERF_EN
    ,
    output logic [31:0] perf_req_cnt,
    output logic [31:0] perf_stall_cnt,
    output logic [15:0] perf_err_cnt
`endif
);
    import uop_pkg::*;

    localparam int CW = (N_CASE > 1) ? $clog2(N_CASE) : 1;
    localparam int SW = $clog2(MAX_LEN + 1);
    localparam int IW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

    typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_BUBBLE, S_DONE} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   case_q;
    logic [XLEN-1:0] acc_q, b_q;
    logic [SW-1:0]   idx_q;
    logic            err_q;

    logic            in_legal, last_step, use_imm, ff_bit;
    logic [CW-1:0]   in_case_s, case_s;
    logic [IW-1:0]   idx_s;
    logic [SW-1:0]   in_len, cur_len;
    op_t             cur_op;
    logic [XLEN-1:0] cur_imm;

    // Table lookups; out-of-range case indices are steered to entry 0 and never used.
    always_comb begin
        in_legal  = int'(bus.in_case) < N_CASE;
        in_case_s = in_legal ? bus.in_case : '0;
        in_len    = SW'(len_table_pkg::LEN_LUT[in_case_s]);
        case_s    = (int'(case_q) < N_CASE) ? case_q : '0;
        idx_s     = idx_q[IW-1:0];
        cur_len   = SW'(len_table_pkg::LEN_LUT[case_s]);
        cur_op    = len_table_pkg::OPS_LUT[case_s][idx_s];
        use_imm   = len_table_pkg::USE_IMM_LUT[case_s][idx_s];
        ff_bit    = len_table_pkg::FF_MASK_LUT[case_s][idx_s];
        cur_imm   = XLEN'(len_table_pkg::IMM_LUT[case_s][idx_s]);
        last_step = (idx_q == cur_len - 1'b1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d           = state_q;
        bus.in_ready      = 1'b0;
        bus.alu_req_valid = 1'b0;
        bus.alu_op        = OP_NOP;
        bus.alu_a         = '0;
        bus.alu_b         = '0;
        bus.out_valid     = 1'b0;
        bus.out_data      = '0;
        bus.out_err       = 1'b0;
        case (state_q)
            S_IDLE: begin
                bus.in_ready = rst_n;
                if (bus.in_valid) begin
                    if (!in_legal || in_len == '0) state_d = S_DONE;
                    else                           state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                bus.alu_req_valid = 1'b1;
                bus.alu_op        = cur_op;
                bus.alu_a         = acc_q;
                bus.alu_b         = use_imm ? cur_imm : b_q;
                if (bus.alu_req_ready) state_d = S_WAIT;
            end
            S_WAIT: begin
                if (bus.alu_rsp_valid) begin
                    if (last_step)   state_d = S_DONE;
                    else if (ff_bit) state_d = S_BUBBLE;
                    else             state_d = S_ISSUE;
                end
            end
            S_BUBBLE: state_d = S_ISSUE;
            S_DONE: begin
                bus.out_valid = 1'b1;
                bus.out_data  = acc_q;
                bus.out_err   = err_q;
                if (bus.out_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            case_q <= '0;
            acc_q  <= '0;
            b_q    <= '0;
            idx_q  <= '0;
            err_q  <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: if (bus.in_valid) begin
                    case_q <= bus.in_case;
                    acc_q  <= in_legal ? bus.in_a : '0;
                    b_q    <= bus.in_b;
                    idx_q  <= '0;
                    err_q  <= !in_legal;
                end
                S_WAIT: if (bus.alu_rsp_valid) begin
                    acc_q <= bus.alu_rsp_data;
                    if (!last_step) idx_q <= idx_q + 1'b1;
                end
                S_DONE: if (bus.out_ready) err_q <= 1'b0;
                default: ;
            endcase
        end
    end

`ifdef FUSE_SEQ_PERF_EN
    logic req_evt, stall_evt, err_evt;
    always_comb begin
        req_evt   = (state_q == S_DONE) && bus.out_ready;
        stall_evt = ((state_q == S_ISSUE) && !bus.alu_req_ready) ||
                    ((state_q == S_DONE)  && !bus.out_ready);
        err_evt   = (state_q == S_IDLE) && bus.in_valid && !in_legal;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_req_cnt   <= '0;
            perf_stall_cnt <= '0;
            perf_err_cnt   <= '0;
        end else begin
            if (req_evt   && perf_req_cnt   != '1) perf_req_cnt   <= perf_req_cnt + 1'b1;
            if (stall_evt && perf_stall_cnt != '1) perf_stall_cnt <= perf_stall_cnt + 1'b1;
            if (err_evt   && perf_err_cnt   != '1) perf_err_cnt   <= perf_err_cnt + 1'b1;
        end
    end
`endif
endmodule

// File: tb/tb_fuse_seq_ctrl.sv
// Directed bench for fuse_seq_ctrl with a 1-cycle (or delayed) ALU model and issue/result scoreboards.
module tb_fuse_seq_ctrl;
    import uop_pkg::*;

    logic clk;
    logic rst_n;

    fuse_seq_if #(.XLEN(32)) bus ();

`ifdef FUSE_SEQ_PERF_EN
    logic [31:0] perf_req_cnt, perf_stall_cnt;
    logic [15:0] perf_err_cnt;
    fuse_seq_ctrl #(.XLEN(32)) dut (.clk(clk), .rst_n(rst_n), .bus(bus),
        .perf_req_cnt(perf_req_cnt), .perf_stall_cnt(perf_stall_cnt), .perf_err_cnt(perf_err_cnt));
`else
    fuse_seq_ctrl #(.XLEN(32)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
`endif

    typedef struct { op_t op; logic [31:0] a; logic [31:0] b; } iss_t;
    typedef struct { logic [31:0] data; logic err; } res_t;

    iss_t iss_q[$];
    res_t res_q[$];
    iss_t mon_iss;
    res_t mon_res;

    int n_vec = 0, n_err = 0, cyc = 0, issue_cnt = 0, alu_delay = 0;
    logic        alu_pend;
    int          alu_cnt;
    logic [31:0] alu_res;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded its time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] alu_fn(input op_t op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            OP_ADD:  return a + b;
            OP_SUB:  return a - b;
            OP_IMUL: return a * b;
            OP_INC:  return a + 32'd1;
            OP_SHL:  return a << b[4:0];
            default: return 32'd0;
        endcase
    endfunction

    // ALU model: responds alu_delay cycles after the cycle following the issue handshake.
    initial begin
        bus.alu_rsp_valid = 1'b0;
        bus.alu_rsp_data  = '0;
        alu_pend = 1'b0;
        alu_cnt  = 0;
        alu_res  = '0;
        forever begin
            @(negedge clk);
            bus.alu_rsp_valid = 1'b0;
            if (alu_pend) begin
                if (alu_cnt == 0) begin
                    bus.alu_rsp_valid = 1'b1;
                    bus.alu_rsp_data  = alu_res;
                    alu_pend = 1'b0;
                end else begin
                    alu_cnt--;
                end
            end
            if (bus.alu_req_valid && bus.alu_req_ready) begin
                alu_pend = 1'b1;
                alu_cnt  = alu_delay;
                alu_res  = alu_fn(bus.alu_op, bus.alu_a, bus.alu_b);
            end
        end
    end

    // Scoreboard monitor for ALU issues and output handshakes.
    initial forever begin
        @(negedge clk);
        if (rst_n && bus.alu_req_valid && bus.alu_req_ready) begin
            issue_cnt++;
            check("alu_issue_expected", 64'(iss_q.size() != 0), 64'd1);
            if (iss_q.size() != 0) begin
                mon_iss = iss_q.pop_front();
                check("alu_op", 64'(bus.alu_op), 64'(mon_iss.op));
                check("alu_a",  64'(bus.alu_a),  64'(mon_iss.a));
                check("alu_b",  64'(bus.alu_b),  64'(mon_iss.b));
            end
        end
        if (rst_n && bus.out_valid && bus.out_ready) begin
            check("out_expected", 64'(res_q.size() != 0), 64'd1);
            if (res_q.size() != 0) begin
                mon_res = res_q.pop_front();
                check("out_data", 64'(bus.out_data), 64'(mon_res.data));
                check("out_err",  64'(bus.out_err),  64'(mon_res.err));
            end
        end
    end

    task automatic push_iss(input op_t op, input logic [31:0] a, input logic [31:0] b);
        iss_t e;
        e.op = op; e.a = a; e.b = b;
        iss_q.push_back(e);
    endtask

    task automatic push_res(input logic [31:0] d, input logic e);
        res_t r;
        r.data = d; r.err = e;
        res_q.push_back(r);
    endtask

    task automatic send(input logic [1:0] c, input logic [31:0] a, input logic [31:0] b, output int t_acc);
        @(posedge clk); #1;
        bus.in_valid = 1'b1; bus.in_case = c; bus.in_a = a; bus.in_b = b;
        t_acc = -1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (bus.in_ready) begin
                t_acc = cyc;
                break;
            end
        end
        check("in_accept", 64'(t_acc >= 0), 64'd1);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_out(output int t_out);
        t_out = -1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (bus.out_valid) begin
                t_out = cyc;
                break;
            end
        end
        check("out_arrives", 64'(t_out >= 0), 64'd1);
    endtask

    int ta, to, ic0, seen;

    initial begin
        rst_n = 1'b0;
        bus.in_valid = 1'b0; bus.in_case = '0; bus.in_a = '0; bus.in_b = '0;
        bus.alu_req_ready = 1'b1;
        bus.out_ready = 1'b1;
        #1;
        check("rst_in_ready",  64'(bus.in_ready), 64'd0);
        check("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("rst_alu_valid", 64'(bus.alu_req_valid), 64'd0);
        check("rst_out_data",  64'(bus.out_data), 64'd0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("idle_in_ready", 64'(bus.in_ready), 64'd1);

        // Case 0: IMUL then ADD, 1-cycle ALU
        push_iss(OP_IMUL, 32'd3, 32'd4);
        push_iss(OP_ADD, 32'd12, 32'd4);
        push_res(32'd16, 1'b0);
        send(2'd0, 32'd3, 32'd4, ta);
        wait_out(to);
        check("lat_case0", 64'(to - ta), 64'd5);
        @(negedge clk);
        check("b2b_in_ready", 64'(bus.in_ready), 64'd1);

        // Case 2: INC then SHL by immediate 2
        push_iss(OP_INC, 32'd7, 32'd1);
        push_iss(OP_SHL, 32'd8, 32'd2);
        push_res(32'd32, 1'b0);
        send(2'd2, 32'd7, 32'd1, ta);
        wait_out(to);
        check("lat_case2", 64'(to - ta), 64'd5);

        // Illegal case index
        ic0 = issue_cnt;
        push_res(32'd0, 1'b1);
        send(2'd3, 32'd9, 32'd9, ta);
        wait_out(to);
        check("lat_illegal", 64'(to - ta), 64'd1);
        check("illegal_no_issue", 64'(issue_cnt - ic0), 64'd0);

        push_iss(OP_IMUL, 32'd2, 32'd5);
        push_iss(OP_ADD, 32'd10, 32'd5);
        push_res(32'd15, 1'b0);
        send(2'd0, 32'd2, 32'd5, ta);
        wait_out(to);

        // Stall on issue and on output
        ic0 = issue_cnt;
        bus.alu_req_ready = 1'b0;
        push_iss(OP_IMUL, 32'd5, 32'd6);
        push_iss(OP_ADD, 32'd30, 32'd6);
        push_res(32'd36, 1'b0);
        send(2'd0, 32'd5, 32'd6, ta);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("stall_req_valid", 64'(bus.alu_req_valid), 64'd1);
            check("stall_alu_op", 64'(bus.alu_op), 64'(OP_IMUL));
            check("stall_alu_a",  64'(bus.alu_a), 64'd5);
            check("stall_alu_b",  64'(bus.alu_b), 64'd6);
        end
        @(posedge clk); #1;
        bus.alu_req_ready = 1'b1;
        bus.out_ready = 1'b0;
        wait_out(to);
        for (int i = 0; i < 3; i++) begin
            if (i != 0) @(negedge clk);
            check("hold_out_valid", 64'(bus.out_valid), 64'd1);
            check("hold_out_data",  64'(bus.out_data), 64'd36);
            check("hold_out_err",   64'(bus.out_err), 64'd0);
        end
        @(posedge clk); #1;
        bus.out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("stall_issue_count", 64'(issue_cnt - ic0), 64'd2);

        // Reset while waiting on the ALU in case 1
        alu_delay = 3;
        push_iss(OP_ADD, 32'd10, 32'd5);
        send(2'd1, 32'd10, 32'd3, ta);
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.alu_req_valid && bus.alu_req_ready) begin
                seen = 1;
                break;
            end
        end
        check("rst_test_issue", 64'(seen), 64'd1);
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        check("midrst_in_ready",  64'(bus.in_ready), 64'd0);
        check("midrst_alu_valid", 64'(bus.alu_req_valid), 64'd0);
        check("midrst_alu_op",    64'(bus.alu_op), 64'd0);
        check("midrst_alu_a",     64'(bus.alu_a), 64'd0);
        check("midrst_alu_b",     64'(bus.alu_b), 64'd0);
        check("midrst_out_valid", 64'(bus.out_valid), 64'd0);
        check("midrst_out_data",  64'(bus.out_data), 64'd0);
        check("midrst_out_err",   64'(bus.out_err), 64'd0);
        @(posedge clk);
        @(posedge clk); #1;
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (bus.out_valid || bus.alu_req_valid) seen++;
        end
        check("late_rsp_ignored", 64'(seen), 64'd0);
        check("iss_sb_drained", 64'(iss_q.size()), 64'd0);
        alu_delay = 0;

        // Fresh case 1 request: ADD imm 5, one bubble, then SUB b
        push_iss(OP_ADD, 32'd10, 32'd5);
        push_iss(OP_SUB, 32'd15, 32'd3);
        push_res(32'd12, 1'b0);
        send(2'd1, 32'd10, 32'd3, ta);
        wait_out(to);
        check("lat_case1_bubble", 64'(to - ta), 64'd6);
        @(negedge clk);
        check("final_in_ready", 64'(bus.in_ready), 64'd1);

        repeat (3) @(negedge clk);
        check("iss_sb_empty", 64'(iss_q.size()), 64'd0);
        check("res_sb_empty", 64'(res_q.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/fuse_seq_ctrl.md
Name: fuse_seq_ctrl

Overview:
Sequencer for the fused-uop case table in len_table_pkg.
- Accepts one fused-op request (case index plus two operands).
- Walks OPS_LUT[case][0..LEN_LUT[case]-1] in order, issuing each uop to a shared external ALU over a valid/ready request and response channel.
- Chains each ALU result into an accumulator and returns the final value on an output valid/ready channel.
- Sits between the fused-op decode stage and the shared ALU; one request is in flight at a time.

Parameters:
- N_CASE, len_table_pkg::N_CASE (3): number of fused cases; width of the case index is $clog2(N_CASE), minimum 1.
- MAX_LEN, len_table_pkg::MAX_LEN (2): maximum uops per case; width of the step index is $clog2(MAX_LEN+1).
- XLEN, 32: operand, immediate and result width.

Ports:
- clk, input, 1: clock.
- rst_n, input, 1: asynchronous active-low reset.
- in_valid, input, 1: request valid.
- in_ready, output, 1: request ready; high only in IDLE.
- in_case, input, CW: case index.
- in_a, input, XLEN: source A; initial accumulator value.
- in_b, input, XLEN: source B; second operand for non-immediate uops.
- alu_req_valid, output, 1: ALU issue valid.
- alu_req_ready, input, 1: ALU accepts the issue.
- alu_op, output, uop_pkg::op_t: uop opcode.
- alu_a, output, XLEN: accumulator.
- alu_b, output, XLEN: immediate or latched B.
- alu_rsp_valid, input, 1: ALU result valid.
- alu_rsp_data, input, XLEN: ALU result.
- out_valid, output, 1: result valid.
- out_ready, input, 1: consumer ready.
- out_data, output, XLEN: final accumulator.
- out_err, output, 1: request had an illegal case index.

Behaviour:
- Reset (asynchronous, rst_n low): state goes to IDLE; all outputs and internal registers clear to 0, including acc, b_q, case_q and idx. The only exception is in_ready, which reads 1 once rst_n is high.
- States: IDLE, ISSUE, WAIT, BUBBLE, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid: latch case_q=in_case, acc=in_a, b_q=in_b, idx=0.
  - If in_case>=N_CASE: out_err_q=1, acc=0, go to DONE.
  - Else if LEN_LUT[in_case]==0: go to DONE with acc=in_a.
  - Else go to ISSUE.
- ISSUE:
  - alu_req_valid=1.
  - alu_op=OPS_LUT[case_q][idx].
  - alu_a=acc.
  - alu_b = USE_IMM_LUT[case_q][idx] ? IMM_LUT[case_q][idx] : b_q.
  - Stay in ISSUE until alu_req_ready, then go to WAIT. alu_req_valid drops the cycle after the handshake.
  - Issue outputs are held stable while stalled.
- WAIT:
  - On alu_rsp_valid: acc<=alu_rsp_data.
  - If idx==LEN_LUT[case_q]-1, go to DONE.
  - Else, if FF_MASK_LUT[case_q][idx] is set, go to BUBBLE; otherwise go to ISSUE.
  - In both non-final cases, idx<=idx+1.
  - alu_rsp_valid outside WAIT is ignored.
- BUBBLE: exactly one idle cycle (pipeline register stage), then ISSUE.
- DONE:
  - out_valid=1, out_data=acc, out_err=out_err_q.
  - On out_ready: go to IDLE and clear out_err_q.
  - out_data and out_err are held stable while out_valid && !out_ready.
- Latency with a 1-cycle ALU (ready always high, rsp the cycle after issue), LEN=2, no FF bits: accept at T, ISSUE at T+1, WAIT at T+2, ISSUE at T+3, WAIT at T+4, out_valid at T+5. Add 1 cycle per set FF bit.
- Back-to-back: in_ready returns the cycle after the out handshake. There is no combinational in-to-out path.
- Arithmetic is the ALU's responsibility. The block only truncates or passes XLEN bits.
- Reset mid-operation abandons the request; no output is produced.

Optional Feature:
FUSE_SEQ_PERF_EN.
- When defined, three extra output ports exist:
  - perf_req_cnt, 32 bits: completed out handshakes.
  - perf_stall_cnt, 32 bits: cycles in ISSUE with !alu_req_ready, plus cycles in DONE with !out_ready.
  - perf_err_cnt, 16 bits: illegal-case requests.
- All three counters are saturating and cleared by rst_n.
- When undefined, these ports and counters are absent and behaviour is otherwise identical.

Test Plan:
- Case 0 (IMUL, ADD), a=3, b=4; bench ALU 1-cycle, always ready -> alu ops IMUL(3,4) then ADD(12,4); out_data=16 at T+5, out_err=0.
- Case 2 (INC, SHL), a=7, b=1 -> ops INC then SHL issued with alu_a=7 then alu_a=8; out_data equals the bench model result; idx wraps back to 0 for the next request.
- in_case=3 (illegal) -> no ALU issue, out_valid at T+1 with out_err=1 and out_data=0; the next legal request has out_err=0.
- alu_req_ready held low for 5 cycles and out_ready held low for 3 cycles -> alu_op, alu_a, alu_b, out_data and out_err stable throughout; exactly one issue per uop.
- rst_n asserted in WAIT of case 1 -> all outputs 0 immediately; a late alu_rsp_valid is ignored; a fresh request completes correctly.
- Forced FF_MASK bit 0 set (test package override) -> exactly one BUBBLE cycle between the first response and the second issue; latency T+6.
